// File: rtl/maze_carver.sv
// Recursive-backtracker maze generator: walks a W x H grid from (0,0) and emits one
// carve event per wall removed, backtracking through an on-chip coordinate stack.
module maze_carver #(
  parameter int unsigned W  = 8,
  parameter int unsigned H  = 8,
  parameter int unsigned XW = 3,
  parameter int unsigned YW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [1:0]    i_rand,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_carve_valid,
  output logic [XW-1:0] o_carve_x,
  output logic [YW-1:0] o_carve_y,
  output logic [1:0]    o_carve_dir
);

  localparam int unsigned Cells = W * H;
  localparam int unsigned Depth = Cells - 1;
  localparam int unsigned IW    = $clog2(Cells);
  localparam int unsigned SPW   = $clog2(Cells);

  typedef enum logic [2:0] {StIdle, StInit, StPick, StCheck, StPop, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [XW-1:0]     r_cx, w_cx_d, w_nx;
  logic [YW-1:0]     r_cy, w_cy_d, w_ny;
  logic [SPW-1:0]    r_sp, w_sp_d, w_pidx;
  logic [1:0]        r_base, w_base_d, r_try, w_try_d, w_dir;
  logic              r_busy, w_busy_d, r_done, w_done_d;
  logic              r_cv, w_cv_d;
  logic [XW-1:0]     r_ox, w_ox_d;
  logic [YW-1:0]     r_oy, w_oy_d;
  logic [1:0]        r_od, w_od_d;
  logic [Cells-1:0]  r_visited;
  logic [XW+YW-1:0]  r_stack [Depth];
  logic [XW+YW-1:0]  w_top;
  logic [IW-1:0]     w_nidx;
  logic              w_inb, w_free, w_vis_clr, w_vis_set, w_push;

  assign w_dir  = r_base + r_try;
  assign w_pidx = r_sp - 1'b1;
  assign w_top  = r_stack[w_pidx];

  // Neighbour in the direction under test; w_inb rejects any wrap-around.
  always_comb begin
    w_nx  = r_cx;
    w_ny  = r_cy;
    w_inb = 1'b0;
    unique case (w_dir)
      2'd0: begin w_inb = (r_cy != '0);            w_ny = r_cy - 1'b1; end
      2'd1: begin w_inb = (r_cx != XW'(W - 1));    w_nx = r_cx + 1'b1; end
      2'd2: begin w_inb = (r_cy != YW'(H - 1));    w_ny = r_cy + 1'b1; end
      default: begin w_inb = (r_cx != '0);         w_nx = r_cx - 1'b1; end
    endcase
    w_nidx = IW'(w_ny) * IW'(W) + IW'(w_nx);
    w_free = w_inb && !r_visited[w_nidx];
  end

  always_comb begin
    w_state_d = r_state;
    w_cx_d    = r_cx;
    w_cy_d    = r_cy;
    w_sp_d    = r_sp;
    w_base_d  = r_base;
    w_try_d   = r_try;
    w_busy_d  = r_busy;
    w_done_d  = r_done;
    w_cv_d    = 1'b0;
    w_ox_d    = r_ox;
    w_oy_d    = r_oy;
    w_od_d    = r_od;
    w_vis_clr = 1'b0;
    w_vis_set = 1'b0;
    w_push    = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_d = StInit;
          w_done_d  = 1'b0;
          w_busy_d  = 1'b1;
        end
      end
      StInit: begin
        w_vis_clr = 1'b1;
        w_cx_d    = '0;
        w_cy_d    = '0;
        w_sp_d    = '0;
        w_state_d = StPick;
      end
      StPick: begin
        w_base_d  = i_rand;
        w_try_d   = 2'd0;
        w_state_d = StCheck;
      end
      StCheck: begin
        if (w_free) begin
          w_cv_d    = 1'b1;
          w_ox_d    = r_cx;
          w_oy_d    = r_cy;
          w_od_d    = w_dir;
          w_push    = 1'b1;
          w_sp_d    = r_sp + 1'b1;
          w_vis_set = 1'b1;
          w_cx_d    = w_nx;
          w_cy_d    = w_ny;
          w_state_d = StPick;
        end else if (r_try == 2'd3) begin
          w_state_d = StPop;
        end else begin
          w_try_d = r_try + 1'b1;
        end
      end
      StPop: begin
        if (r_sp == '0) begin
          w_state_d = StDone;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b1;
        end else begin
          w_sp_d    = w_pidx;
          w_cx_d    = w_top[XW+YW-1:YW];
          w_cy_d    = w_top[YW-1:0];
          w_state_d = StPick;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cx      <= '0;
      r_cy      <= '0;
      r_sp      <= '0;
      r_base    <= '0;
      r_try     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cv      <= 1'b0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_od      <= '0;
      r_visited <= '0;
    end else begin
      r_state <= w_state_d;
      r_cx    <= w_cx_d;
      r_cy    <= w_cy_d;
      r_sp    <= w_sp_d;
      r_base  <= w_base_d;
      r_try   <= w_try_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_cv    <= w_cv_d;
      r_ox    <= w_ox_d;
      r_oy    <= w_oy_d;
      r_od    <= w_od_d;
      // Index 0 is cell (0,0), the walk's starting point.
      if (w_vis_clr) begin
        r_visited <= Cells'(1);
      end else if (w_vis_set) begin
        r_visited[w_nidx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[r_sp] <= {r_cx, r_cy};
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_carve_valid = r_cv;
  assign o_carve_x     = r_ox;
  assign o_carve_y     = r_oy;
  assign o_carve_dir   = r_od;

endmodule

// File: tb/tb_maze_carver.sv
// Directed bench for maze_carver: an 8x8 and a 2x2 instance, carve events captured on the
// falling edge and checked against hand-derived sequences and a spanning-tree model.
module tb_maze_carver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, busy8, done8, cv8;
  logic [1:0] rand8, cd8;
  logic [2:0] cx8, cy8;
  logic       start2, busy2, done2, cv2;
  logic [1:0] rand2, cd2;
  logic [2:0] cx2, cy2;

  maze_carver u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(start8), .i_rand(rand8),
    .o_busy(busy8), .o_done(done8), .o_carve_valid(cv8),
    .o_carve_x(cx8), .o_carve_y(cy8), .o_carve_dir(cd8)
  );

  maze_carver #(.W(2), .H(2), .XW(3), .YW(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(start2), .i_rand(rand2),
    .o_busy(busy2), .o_done(done2), .o_carve_valid(cv2),
    .o_carve_x(cx2), .o_carve_y(cy2), .o_carve_dir(cd2)
  );

  typedef struct {int x; int y; int d;} ev_t;
  ev_t q8[$];
  ev_t q2[$];

  always @(negedge clk) begin
    if (cv8) q8.push_back('{x: int'(cx8), y: int'(cy8), d: int'(cd8)});
    if (cv2) q2.push_back('{x: int'(cx2), y: int'(cy2), d: int'(cd2)});
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the 8x8 run to finish; optionally randomises rand and pokes start at step poke.
  task automatic wait_done8(input string tag, input bit rnd, input int poke);
    int n = 0;
    while (!done8 && n < 5000) begin
      if (rnd) rand8 = 2'($urandom_range(0, 3));
      start8 = (n == poke);
      tick();
      n++;
      if (n == poke + 1) check({tag, "_busy_after_poke"}, 32'(busy8), 32'd1);
    end
    start8 = 1'b0;
    check({tag, "_done"}, 32'(done8), 32'd1);
    check({tag, "_busy_low"}, 32'(busy8), 32'd0);
  endtask

  task automatic wait_done2(input string tag);
    int n = 0;
    while (!done2 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(done2), 32'd1);
    check({tag, "_busy_low"}, 32'(busy2), 32'd0);
  endtask

  // Replays the carve log on an 8x8 grid: every target in bounds, new, reached from a visited cell.
  task automatic analyze8(input string tag);
    bit vis [8][8];
    int oob = 0, rev = 0, src = 0, reached = 0, nx, ny;
    foreach (vis[i, j]) vis[i][j] = 1'b0;
    vis[0][0] = 1'b1;
    check({tag, "_count"}, 32'(q8.size()), 32'd63);
    foreach (q8[i]) begin
      nx = q8[i].x + ((q8[i].d == 1) ? 1 : (q8[i].d == 3) ? -1 : 0);
      ny = q8[i].y + ((q8[i].d == 2) ? 1 : (q8[i].d == 0) ? -1 : 0);
      if (nx < 0 || nx > 7 || ny < 0 || ny > 7) oob++;
      else begin
        if (!vis[q8[i].x][q8[i].y]) src++;
        if (vis[nx][ny]) rev++;
        vis[nx][ny] = 1'b1;
      end
    end
    foreach (vis[i, j]) if (vis[i][j]) reached++;
    check({tag, "_out_of_bounds"}, 32'(oob), 32'd0);
    check({tag, "_revisits"}, 32'(rev), 32'd0);
    check({tag, "_unreached_src"}, 32'(src), 32'd0);
    check({tag, "_cells_reached"}, 32'(reached), 32'd64);
    q8.delete();
  endtask

  // 2x2 walk from (0,0) with rand 01 or 11: E, then S, then W; encoded x*100+y*10+d.
  task automatic check2x2(input string tag, input int exp_lat);
    int lat = 0;
    int exp_ev [3] = '{1, 102, 113};
    int obs;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check({tag, "_busy_first_cycle"}, 32'(busy2), 32'd1);
    check({tag, "_done_dropped"}, 32'(done2), 32'd0);
    while (!cv2 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_first_carve_latency"}, 32'(lat), 32'(exp_lat));
    wait_done2(tag);
    check({tag, "_pulses"}, 32'(q2.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      obs = (i < q2.size()) ? q2[i].x * 100 + q2[i].y * 10 + q2[i].d : -1;
      check($sformatf("%s_ev%0d", tag, i), 32'(obs), 32'(exp_ev[i]));
    end
    q2.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n  = 1'b0;
    start8 = 1'b0;
    start2 = 1'b0;
    rand8  = 2'd0;
    rand2  = 2'd0;
    tick();
    tick();
    check("reset_outputs8", {cv8, busy8, done8, cx8, cy8, cd8}, 32'd0);
    check("reset_outputs2", {cv2, busy2, done2, cx2, cy2, cd2}, 32'd0);
    rst_n = 1'b1;
    tick();

    rand2 = 2'b01;
    check2x2("r01", 3);
    rand2 = 2'b11;
    check2x2("r11", 5);

    // Random-direction 8x8 run with a start poke mid-walk that must be ignored.
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("rnd_busy_first_cycle", 32'(busy8), 32'd1);
    wait_done8("rnd", 1'b1, 40);
    analyze8("rnd");
    tick();
    tick();
    check("done_held", 32'(done8), 32'd1);

    // Restart from DONE with rand stuck at N.
    rand8  = 2'b00;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("restart_done_drop", 32'(done8), 32'd0);
    wait_done8("stuck_n", 1'b0, -5);
    analyze8("stuck_n");

    // Reset in the middle of a walk, once ten carves have been logged.
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cnt = 0;
    while (q8.size() < 10 && cnt < 2000) begin
      rand8 = 2'($urandom_range(0, 3));
      tick();
      cnt++;
    end
    check("midrun_ten_carves", 32'(q8.size()), 32'd10);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {cv8, busy8, done8, cx8, cy8, cd8}, 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check("midrun_no_more_pulses", 32'(q8.size()), 32'd10);
    rst_n = 1'b1;
    tick();
    q8.delete();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8("after_reset", 1'b1, -5);
    analyze8("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
